cpu_coherence_ctrl: RTL and testbench

//  Processor-side half of the MSI-style snooping controller for one cache. Takes CPU read/write

---
 rtl/coherence_pkg.sv | 33 +++
 rtl/cpu_coherence_ctrl_if.sv | 50 +++++
 rtl/coherence_line_array.sv | 51 +++++
 rtl/cpu_coherence_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_coherence_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/coherence_pkg.sv
// Encodings shared by the processor-side controller and the bus-side snoop FSM.
//   bus_op_e   : bus operation issued on bus_op
//   line_st_e  : MSI line state held in the tag/state array
//   ctrl_st_e  : processor-side controller FSM state
package coherence_pkg;

  typedef enum logic [1:0] {
    READ_MISS  = 2'b00,
    INVALIDATE = 2'b01,
    WRITE_MISS = 2'b10
  } bus_op_e;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    EXCLUSIVE = 2'b01,
    SHARED    = 2'b10
  } line_st_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_WB,
    S_BUS
  } ctrl_st_e;

  // State a line takes once its bus op completes: a read fill is shared,
  // anything that gains write ownership is exclusive.
  function automatic line_st_e fill_state(bus_op_e op);
    return (op == READ_MISS) ? SHARED : EXCLUSIVE;
  endfunction

endpackage

// File: rtl/cpu_coherence_ctrl_if.sv
// Handshake bundle of the processor-side coherence controller.
//   cpu_req_* / cpu_resp_* : CPU request/completion
//   bus_*                  : bus op request to the arbiter
//   wb_*                   : dirty victim write-back
//   snp_*                  : line state updates from the bus-side snoop FSM
// slave  : controller view.   master : environment (CPU, arbiter, snoop FSM) view.
interface cpu_coherence_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
);
  logic              cpu_req_valid;
  logic              cpu_req_write;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_req_ready;
  logic              cpu_resp_valid;
  logic              cpu_resp_hit;

  logic              bus_req;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_grant;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_ack;

  logic               snp_valid;
  logic [INDEX_W-1:0] snp_index;
  logic [1:0]         snp_state;

  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
    output bus_req, bus_op, bus_addr,
    input  bus_grant,
    output wb_valid, wb_addr,
    input  wb_ack,
    input  snp_valid, snp_index, snp_state
  );

  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
    input  bus_req, bus_op, bus_addr,
    output bus_grant,
    input  wb_valid, wb_addr,
    output wb_ack,
    output snp_valid, snp_index, snp_state
  );
endinterface

// File: rtl/coherence_line_array.sv
// Direct-mapped tag/state array.
//   rd_*   : combinational read port; a snoop to the same line in the same
//            cycle is forwarded so the reader never sees a stale state
//   cpu_*  : controller write port (state, optionally tag); wins over snoop
//   snp_*  : snoop state write port (tag untouched)
module coherence_line_array
  import coherence_pkg::*;
#(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [TAG_W-1:0]   rd_tag,
  output line_st_e           rd_state,
  input  logic               cpu_we,
  input  logic               cpu_tag_we,
  input  logic [INDEX_W-1:0] cpu_index,
  input  logic [TAG_W-1:0]   cpu_tag,
  input  line_st_e           cpu_state,
  input  logic               snp_valid,
  input  logic [INDEX_W-1:0] snp_index,
  input  line_st_e           snp_state
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0][TAG_W-1:0] tag_q;
  logic [LINES-1:0][1:0]       st_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= '0;
      st_q  <= '0;
    end else begin
      if (snp_valid && !(cpu_we && cpu_index == snp_index))
        st_q[snp_index] <= snp_state;
      if (cpu_we) begin
        st_q[cpu_index] <= cpu_state;
        if (cpu_tag_we) tag_q[cpu_index] <= cpu_tag;
      end
    end
  end

  always_comb begin
    rd_tag   = tag_q[rd_index];
    rd_state = line_st_e'(st_q[rd_index]);
    if (snp_valid && snp_index == rd_index) rd_state = snp_state;
  end

endmodule

// File: rtl/cpu_coherence_ctrl.sv
// Processor-side half of an MSI snooping controller for one cache.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bif (slave)  : CPU request/response, bus op request/grant, victim
//                  write-back, snoop state updates
// A request is looked up once; hits respond directly, misses/upgrades go
// through an optional dirty-victim write-back and then one bus op.
module cpu_coherence_ctrl
  import coherence_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
) (
  input logic               clock,
  input logic               reset,
  cpu_coherence_ctrl_if.slave bif
);
  localparam int TAG_W = ADDR_W - INDEX_W;

  ctrl_st_e          st_q, st_d;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  bus_op_e           op_q;
  logic              hit_q;
  logic [TAG_W-1:0]  vic_tag_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   rtag;
  assign idx  = req_addr_q[INDEX_W-1:0];
  assign rtag = req_addr_q[ADDR_W-1:INDEX_W];

  logic [TAG_W-1:0] rd_tag;
  line_st_e         rd_state;
  logic             cpu_we, cpu_tag_we;
  line_st_e         cpu_state;

  coherence_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_arr (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (idx),
    .rd_tag     (rd_tag),
    .rd_state   (rd_state),
    .cpu_we     (cpu_we),
    .cpu_tag_we (cpu_tag_we),
    .cpu_index  (idx),
    .cpu_tag    (rtag),
    .cpu_state  (cpu_state),
    .snp_valid  (bif.snp_valid),
    .snp_index  (bif.snp_index),
    .snp_state  (line_st_e'(bif.snp_state))
  );

  // Lookup decode (meaningful only in S_LOOKUP).
  logic    lk_hit, lk_resp_hit;
  bus_op_e lk_op;
  assign lk_hit      = (rd_tag == rtag) && (rd_state != INVALID);
  assign lk_resp_hit = lk_hit && (!req_write_q || rd_state == EXCLUSIVE);
  assign lk_op       = lk_hit ? INVALIDATE : (req_write_q ? WRITE_MISS : READ_MISS);

  always_comb begin
    st_d       = st_q;
    cpu_we     = 1'b0;
    cpu_tag_we = 1'b0;
    cpu_state  = INVALID;
    case (st_q)
      S_IDLE:   if (bif.cpu_req_valid) st_d = S_LOOKUP;
      S_LOOKUP: begin
        if (lk_resp_hit)                      st_d = S_RESP;
        else if (!lk_hit && rd_state == EXCLUSIVE) st_d = S_WB;
        else                                  st_d = S_BUS;
      end
      S_WB: if (bif.wb_ack) begin
        cpu_we    = 1'b1;
        cpu_state = INVALID;
        st_d      = S_BUS;
      end
      S_BUS: if (bif.bus_grant) begin
        cpu_we     = 1'b1;
        cpu_tag_we = 1'b1;
        cpu_state  = fill_state(op_q);
        st_d       = S_RESP;
      end
      S_RESP:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= S_IDLE;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      op_q        <= READ_MISS;
      hit_q       <= 1'b0;
      vic_tag_q   <= '0;
    end else begin
      st_q <= st_d;
      case (st_q)
        S_IDLE: if (bif.cpu_req_valid) begin
          req_write_q <= bif.cpu_req_write;
          req_addr_q  <= bif.cpu_req_addr;
        end
        S_LOOKUP: begin
          hit_q     <= lk_resp_hit;
          op_q      <= lk_op;
          vic_tag_q <= rd_tag;
        end
        // Another cache took the line while our upgrade waited: we no longer
        // hold the data, so the upgrade must become a full write miss.
        S_BUS: if (!bif.bus_grant && bif.snp_valid && bif.snp_index == idx &&
                   op_q == INVALIDATE && bif.snp_state == INVALID)
          op_q <= WRITE_MISS;
        default: ;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an abandoned transaction
  // never leaks a request in the reset cycle itself.
  assign bif.cpu_req_ready  = !reset && st_q == S_IDLE;
  assign bif.cpu_resp_valid = !reset && st_q == S_RESP;
  assign bif.cpu_resp_hit   = !reset && st_q == S_RESP && hit_q;
  assign bif.bus_req        = !reset && st_q == S_BUS;
  assign bif.bus_op         = reset ? 2'b00 : op_q;
  assign bif.bus_addr       = reset ? '0 : req_addr_q;
  assign bif.wb_valid       = !reset && st_q == S_WB;
  assign bif.wb_addr        = reset ? '0 : {vic_tag_q, idx};

endmodule

// File: tb/tb_cpu_coherence_ctrl.sv
module tb_cpu_coherence_ctrl;
  import coherence_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu_coherence_ctrl_if #(.ADDR_W(8), .INDEX_W(2)) bif ();

  cpu_coherence_ctrl #(.ADDR_W(8), .INDEX_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic line_chk(string tag, int idx, logic [1:0] st, logic [5:0] tg);
    chk({tag, "_state"}, 32'(dut.u_arr.st_q[idx]), 32'(st));
    chk({tag, "_tag"},   32'(dut.u_arr.tag_q[idx]), 32'(tg));
  endtask

  // Called at a negedge; returns at the negedge of the LOOKUP cycle.
  task automatic send(bit w, logic [7:0] a);
    int n = 0;
    bif.cpu_req_valid = 1'b1;
    bif.cpu_req_write = w;
    bif.cpu_req_addr  = a;
    while (!bif.cpu_req_ready && n < 50) begin @(negedge clock); n++; end
    chk("req_accept", 32'(bif.cpu_req_ready), 1);
    @(posedge clock);
    @(negedge clock);
    bif.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_bus();
    int n = 0;
    while (!bif.bus_req && n < 50) begin @(negedge clock); n++; end
    chk("bus_req_seen", 32'(bif.bus_req), 1);
  endtask

  // Check op/addr, hold the grant off for 'hold' cycles, then grant once.
  task automatic bus_xact(logic [1:0] op, logic [7:0] a, int hold);
    wait_bus();
    chk("bus_op", 32'(bif.bus_op), 32'(op));
    chk("bus_addr", 32'(bif.bus_addr), 32'(a));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("bus_req_held", 32'(bif.bus_req), 1);
      chk("bus_op_stable", 32'(bif.bus_op), 32'(op));
    end
    bif.bus_grant = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bif.bus_grant = 1'b0;
    chk("miss_resp_latency", 32'(bif.cpu_resp_valid), 1);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!bif.cpu_resp_valid && n < 50) begin @(negedge clock); n++; end
    chk("resp_seen", 32'(bif.cpu_resp_valid), 1);
    if (exp_q.size() > 0) chk("resp_hit", 32'(bif.cpu_resp_hit), 32'(exp_q.pop_front()));
    else begin
      checks++; failures++;
      $error("FAIL sb_unexpected_resp observed=1 expected=0");
    end
    @(negedge clock);
    chk("resp_one_cycle", 32'(bif.cpu_resp_valid), 0);
  endtask

  initial begin
    bif.cpu_req_valid = 0; bif.cpu_req_write = 0; bif.cpu_req_addr = '0;
    bif.bus_grant = 0; bif.wb_ack = 0;
    bif.snp_valid = 0; bif.snp_index = '0; bif.snp_state = '0;

    // Reset
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(bif.cpu_req_ready), 0);
    chk("rst_resp", 32'(bif.cpu_resp_valid), 0);
    chk("rst_bus_req", 32'(bif.bus_req), 0);
    chk("rst_wb_valid", 32'(bif.wb_valid), 0);
    for (int i = 0; i < 4; i++) line_chk("rst_line", i, INVALID, 6'h00);
    reset = 1'b0;
    #1 chk("ready_after_rst", 32'(bif.cpu_req_ready), 1);

    // 1: read miss 0x05 -> ReadMiss, line1 Shared tag1
    exp_q.push_back(1'b0);
    send(1'b0, 8'h05);
    bus_xact(READ_MISS, 8'h05, 2);
    wait_resp();
    line_chk("t1_line1", 1, SHARED, 6'h01);

    // 2: read hit 0x05 -> response at T+2, no bus traffic
    exp_q.push_back(1'b1);
    send(1'b0, 8'h05);
    chk("t2_lookup_no_resp", 32'(bif.cpu_resp_valid), 0);
    chk("t2_lookup_no_bus", 32'(bif.bus_req), 0);
    @(negedge clock);
    chk("t2_hit_latency", 32'(bif.cpu_resp_valid), 1);
    chk("t2_no_bus", 32'(bif.bus_req), 0);
    wait_resp();

    // 3: write hit on Shared -> Invalidate, line Exclusive
    exp_q.push_back(1'b0);
    send(1'b1, 8'h05);
    bus_xact(INVALIDATE, 8'h05, 0);
    wait_resp();
    line_chk("t3_line1", 1, EXCLUSIVE, 6'h01);

    // 4: read 0x09 evicts Exclusive 0x05 -> write-back then ReadMiss
    exp_q.push_back(1'b0);
    send(1'b0, 8'h09);
    begin
      int n = 0;
      while (!bif.wb_valid && n < 50) begin @(negedge clock); n++; end
    end
    chk("t4_wb_valid", 32'(bif.wb_valid), 1);
    chk("t4_wb_addr", 32'(bif.wb_addr), 32'h05);
    chk("t4_no_bus_during_wb", 32'(bif.bus_req), 0);
    repeat (2) begin
      @(negedge clock);
      chk("t4_wb_held", 32'(bif.wb_valid), 1);
    end
    bif.wb_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bif.wb_ack = 1'b0;
    chk("t4_wb_dropped", 32'(bif.wb_valid), 0);
    line_chk("t4_victim_inv", 1, INVALID, 6'h01);
    bus_xact(READ_MISS, 8'h09, 1);
    wait_resp();
    line_chk("t4_line1", 1, SHARED, 6'h02);

    // 5: upgrade of 0x09 loses the line to a snoop -> WriteMiss
    exp_q.push_back(1'b0);
    send(1'b1, 8'h09);
    wait_bus();
    chk("t5_op_inv", 32'(bif.bus_op), 32'(INVALIDATE));
    bif.snp_valid = 1'b1; bif.snp_index = 2'd1; bif.snp_state = INVALID;
    @(posedge clock);
    @(negedge clock);
    bif.snp_valid = 1'b0;
    line_chk("t5_snooped", 1, INVALID, 6'h02);
    bus_xact(WRITE_MISS, 8'h09, 0);
    wait_resp();
    line_chk("t5_line1", 1, EXCLUSIVE, 6'h02);

    // 7: fill 0x02, then a snoop in the re-read's LOOKUP cycle forces a miss
    exp_q.push_back(1'b0);
    send(1'b0, 8'h02);
    bus_xact(READ_MISS, 8'h02, 0);
    wait_resp();
    line_chk("t7_line2", 2, SHARED, 6'h00);
    exp_q.push_back(1'b0);
    send(1'b0, 8'h02);
    bif.snp_valid = 1'b1; bif.snp_index = 2'd2; bif.snp_state = INVALID;
    @(posedge clock);
    @(negedge clock);
    bif.snp_valid = 1'b0;
    chk("t7_bypass_no_hit", 32'(bif.cpu_resp_valid), 0);
    bus_xact(READ_MISS, 8'h02, 0);
    wait_resp();

    // 6: reset while a bus op is pending abandons it
    send(1'b0, 8'h0e);
    wait_bus();
    chk("t6_op", 32'(bif.bus_op), 32'(READ_MISS));
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t6_bus_req", 32'(bif.bus_req), 0);
    chk("t6_ready", 32'(bif.cpu_req_ready), 0);
    chk("t6_wb", 32'(bif.wb_valid), 0);
    for (int i = 0; i < 4; i++) line_chk("t6_line", i, INVALID, 6'h00);
    reset = 1'b0;
    #1 chk("t6_ready_after", 32'(bif.cpu_req_ready), 1);
    repeat (4) begin
      @(negedge clock);
      chk("t6_quiet_bus", 32'(bif.bus_req), 0);
      chk("t6_quiet_resp", 32'(bif.cpu_resp_valid), 0);
    end
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
